// File: rtl/alu_seq_if.sv
// Handshake/bus bundle for alu_seq.
//   master: producer/consumer side (drives operands, op, flush, out_ready)
//   slave : the ALU (drives in_ready, out_valid, aluRes and the ZF/CF/OF flags)
// Signals:
//   flush            squash any in-flight op this cycle
//   in_valid/ready   issue handshake for input1/input2/aluCtr
//   out_valid/ready  result handshake for aluRes/ZF/CF/OF
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [3:0]       aluCtr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluRes;
  logic             ZF;
  logic             CF;
  logic             OF;

  modport master (
    output flush, in_valid, input1, input2, aluCtr, out_ready,
    input  in_ready, out_valid, aluRes, ZF, CF, OF
  );

  modport slave (
    input  flush, in_valid, input1, input2, aluCtr, out_ready,
    output in_ready, out_valid, aluRes, ZF, CF, OF
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked, registered ALU execute stage.
// Single-cycle ops (and/or/add/xor/nor/sub/slt/sltu/sll/srl/sra/lui) register their result one
// cycle after accept; mul is an iterative shift-add taking WIDTH+1 cycles from accept.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_seq_if slave modport (flush, issue handshake, result handshake, result/flags)
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
  localparam logic [3:0] OpSltu = 4'b1011;
  localparam logic [3:0] OpMul  = 4'b1100;
  localparam logic [3:0] OpLui  = 4'b1101;

  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d, cf_q, cf_d, of_q, of_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] lui_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_of, alu_def, alu_zf;
  logic [WIDTH-1:0] acc_step;
  logic             in_ready;

  assign a     = bus.input1;
  assign b     = bus.input2;
  assign shamt = a[SHW-1:0];

  if (WIDTH >= 32) begin : g_lui_wide
    assign lui_res = {{(WIDTH-16){1'b0}}, b[15:0]} << 16;
  end else begin : g_lui_narrow
    assign lui_res = b << (WIDTH / 2);
  end

  // Single-cycle datapath. alu_def is low for undefined codes so ZF is forced to 0 there.
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_def = 1'b1;
    case (bus.aluCtr)
      OpAnd: alu_res = a & b;
      OpOr:  alu_res = a | b;
      OpXor: alu_res = a ^ b;
      OpNor: alu_res = ~(a | b);
      OpAdd: begin
        {alu_cf, alu_res} = {1'b0, a} + {1'b0, b};
        alu_of = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = a - b;
        alu_cf  = a < b;
        alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OpSll:  alu_res = b << shamt;
      OpSrl:  alu_res = b >> shamt;
      OpSra:  alu_res = $unsigned($signed(b) >>> shamt);
      OpLui:  alu_res = lui_res;
      default: alu_def = 1'b0;
    endcase
    alu_zf = alu_def && (alu_res == '0);
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    of_d     = of_q;
    valid_d  = valid_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = acc_q;
    in_ready = 1'b0;

    if (bus.flush) begin
      // Squash: drop any result or multiply; nothing is accepted this cycle.
      valid_d = 1'b0;
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          in_ready = rst_n && (!valid_q || bus.out_ready);
          if (valid_q && bus.out_ready) valid_d = 1'b0;
          if (bus.in_valid && in_ready) begin
            if (bus.aluCtr == OpMul) begin
              mcand_d  = a;
              mplier_d = b;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = StMul;
            end else begin
              res_d   = alu_res;
              zf_d    = alu_zf;
              cf_d    = alu_cf;
              of_d    = alu_of;
              valid_d = 1'b1;
            end
          end
        end
        StMul: begin
          acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_d = StHold;
            valid_d = 1'b1;
            res_d   = acc_step;
            zf_d    = (acc_step == '0);
            cf_d    = 1'b0;
            of_d    = 1'b0;
          end
        end
        StHold: begin
          // No accept in the consume cycle; the next op issues from IDLE.
          if (bus.out_ready) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      res_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.aluRes    = res_q;
  assign bus.ZF        = zf_q;
  assign bus.CF        = cf_q;
  assign bus.OF        = of_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed scenarios followed by random ops
// checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 32;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
  localparam logic [3:0] OpSltu = 4'b1011;
  localparam logic [3:0] OpMul  = 4'b1100;
  localparam logic [3:0] OpLui  = 4'b1101;

  logic clk = 1'b0;
  logic rst_n;

  int errors = 0;
  int checks = 0;
  logic [34:0] last_obs;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {res, zf, cf, of} from plain 64-bit arithmetic.
  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned t;
    longint          s;
    int              k = int'(a % 32);
    logic [31:0]     r = '0;
    logic            cf = 1'b0, of = 1'b0, def = 1'b1;
    case (op)
      OpAnd: r = a & b;
      OpOr:  r = a | b;
      OpXor: r = a ^ b;
      OpNor: r = ~(a | b);
      OpAdd: begin
        t = ua + ub; r = t[31:0]; cf = t[32];
        s = sa + sb; of = (s != longint'($signed(s[31:0])));
      end
      OpSub: begin
        r = a - b; cf = (ua < ub);
        s = sa - sb; of = (s != longint'($signed(s[31:0])));
      end
      OpSlt:  r = (sa < sb) ? 32'd1 : 32'd0;
      OpSltu: r = (ua < ub) ? 32'd1 : 32'd0;
      OpSll:  r = 32'(ub << k);
      OpSrl:  r = 32'(ub >> k);
      OpSra:  begin s = sb >>> k; r = s[31:0]; end
      OpLui:  begin t = (ub % 65536) * 65536; r = t[31:0]; end
      OpMul:  begin t = ua * ub; r = t[31:0]; end
      default: begin def = 1'b0; r = '0; end
    endcase
    return {r, def && (r == 32'd0), cf, of};
  endfunction

  // Issue one op from a negedge, wait for its result (bounded), check latency/result,
  // optionally hold the result for 'hold' cycles, then consume. Returns at a negedge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [34:0] exp = model(op, a, b);
    int lat = 0;
    bit rdy_bad = 0;
    bus.aluCtr    = op;
    bus.input1    = a;
    bus.input2    = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    #1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.input1   = $urandom;
    bus.input2   = $urandom;
    do begin
      @(negedge clk);
      lat++;
      if (bus.in_ready) rdy_bad = 1;
    end while (!bus.out_valid && lat < 60);
    check({tag, " latency"}, 64'(lat), (op == OpMul) ? 64'(W + 1) : 64'd1);
    if (op == OpMul) check({tag, " mul in_ready low"}, 64'(rdy_bad), 64'd0);
    last_obs = {bus.aluRes, bus.ZF, bus.CF, bus.OF};
    check({tag, " result"}, 64'(last_obs), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold"}, 64'({bus.out_valid, bus.in_ready, bus.aluRes, bus.ZF, bus.CF,
                                 bus.OF}), 64'({1'b1, 1'b0, exp}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [3:0]  ops [16];
    logic [31:0] corner [5];
    logic [31:0] ra, rb;
    int          seen;

    ops = '{OpAnd, OpOr, OpAdd, OpXor, OpNor, OpSub, OpSlt, OpSltu, OpSll, OpSrl, OpSra,
            OpLui, OpMul, 4'b0101, 4'b1110, 4'b1111};
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    // Reset
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.input1    = '0;
    bus.input2    = '0;
    bus.aluCtr    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 64'({bus.out_valid, bus.aluRes, bus.ZF, bus.CF, bus.OF}), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Add overflow / carry
    run_op(OpAdd, 32'h7FFF_FFFF, 32'd1, 0, "add ovf");
    check("add ovf const", 64'(last_obs), 64'({32'h8000_0000, 1'b0, 1'b0, 1'b1}));
    run_op(OpAdd, 32'hFFFF_FFFF, 32'd1, 0, "add carry");
    check("add carry const", 64'(last_obs), 64'({32'h0, 1'b1, 1'b1, 1'b0}));

    // Sub / set-less-than
    run_op(OpSub, 32'd3, 32'd5, 0, "sub");
    check("sub const", 64'(last_obs), 64'({32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0}));
    run_op(OpSlt, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    check("slt const", 64'(last_obs), 64'({32'd1, 1'b0, 1'b0, 1'b0}));
    run_op(OpSltu, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
    check("sltu const", 64'(last_obs), 64'({32'd0, 1'b1, 1'b0, 1'b0}));

    // Shifts
    run_op(OpSra, 32'd4, 32'h8000_0000, 0, "sra");
    check("sra const", 64'(last_obs), 64'({32'hF800_0000, 1'b0, 1'b0, 1'b0}));
    run_op(OpSrl, 32'd36, 32'h100, 0, "srl");
    check("srl const", 64'(last_obs), 64'({32'h10, 1'b0, 1'b0, 1'b0}));
    run_op(OpLui, 32'd0, 32'h1234_ABCD, 0, "lui");
    check("lui const", 64'(last_obs), 64'({32'hABCD_0000, 1'b0, 1'b0, 1'b0}));

    // Multiply
    run_op(OpMul, 32'd12345, 32'd678, 0, "mul");
    check("mul const", 64'(last_obs), 64'({32'd8369910, 1'b0, 1'b0, 1'b0}));
    run_op(OpMul, 32'h10000, 32'h10000, 0, "mul zero");
    check("mul zero const", 64'(last_obs), 64'({32'd0, 1'b1, 1'b0, 1'b0}));
    run_op(OpMul, 32'd7, 32'd9, 3, "mul hold");

    // Backpressure, then back-to-back issue on consume
    bus.aluCtr = OpAnd; bus.input1 = 32'hF0; bus.input2 = 32'h3C;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold", 64'({bus.out_valid, bus.in_ready, bus.aluRes, bus.ZF, bus.CF, bus.OF}),
            64'({1'b1, 1'b0, 32'h30, 3'b000}));
    end
    bus.aluCtr = OpAdd; bus.input1 = 32'd5; bus.input2 = 32'd6;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check("bp ready on consume", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp next result", 64'({bus.out_valid, bus.aluRes, bus.ZF, bus.CF, bus.OF}),
          64'({1'b1, 32'd11, 3'b000}));
    @(negedge clk);

    // Flush during mul, with an op offered in the flush cycle
    bus.aluCtr = OpMul; bus.input1 = 32'd3; bus.input2 = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1; bus.aluCtr = OpAdd; bus.in_valid = 1'b1;
    #1;
    check("flush in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 begin bus.flush = 1'b0; bus.in_valid = 1'b0; end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush no result", 64'(seen), 64'd0);

    // Reset during mul
    bus.aluCtr = OpMul; bus.input1 = 32'd5; bus.input2 = 32'd6; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst mid-mul outputs",
          64'({bus.out_valid, bus.aluRes, bus.ZF, bus.CF, bus.OF}), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst no result", 64'(seen), 64'd0);
    run_op(OpAdd, 32'd2, 32'd2, 0, "add after rst");
    check("add after rst const", 64'(last_obs), 64'({32'd4, 3'b000}));

    // Random ops against the model
    for (int n = 0; n < 150; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      run_op(ops[$urandom_range(0, 15)], ra, rb,
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
